lvt_nwmr_param: RTL and testbench
=================================

Name: lvt_nwmr_param

Overview:
- Parametrised live value table (LVT) for multi-ported register files built from banked 1W/nR memories.
- Generalises the fixed 2-write/4-read LVT to NW write ports, NR read ports and arbitrary depth.
- Records, per address, which write bank (port index) holds the live value.
- Adds three behaviours the fixed block lacks: post-reset table initialisation, same-address write-conflict resolution with a conflict flag, and out-of-range address handling.
- Sits beside the register-file banks; its read outputs drive the bank-select muxes.

Parameters:
- NW, 2, number of write ports (1..8).
- NR, 4, number of read ports (1..16).
- DEPTH, 16, number of table entries.
- ADDR_W, 4, address width; must satisfy 2^ADDR_W >= DEPTH.
- BANK_W, 1, entry width = max(1, ceil(log2(NW))).

Ports:
- clock, in, 1, single clock; all state updates on rising edge.
- reset_n, in, 1, synchronous active-low reset.
- we, in, NW, per-port write enable; bit i belongs to port i.
- write_addr, in, NW*ADDR_W, packed write addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- read_addr, in, NR*ADDR_W, packed read addresses; port j occupies bits [j*ADDR_W +: ADDR_W].
- read_bank, out, NR*BANK_W, registered live-bank indices; port j occupies bits [j*BANK_W +: BANK_W].
- ready, out, 1, high once initialisation is complete.
- conflict, out, 1, registered one-cycle pulse: two or more enabled write ports targeted the same in-range address in the previous cycle.

Behaviour:
- Reset (reset_n low at a clock edge):
  - FSM enters INIT; init_ptr <= 0.
  - ready <= 0, conflict <= 0, all read_bank <= 0.
  - Inputs are ignored while reset_n is low.
- FSM has two states, INIT and RUN.
- INIT:
  - Each cycle writes entry[init_ptr] <= 0, then increments init_ptr.
  - When init_ptr == DEPTH-1, the write completes and the FSM moves to RUN; ready <= 1 on that same edge.
  - ready therefore rises DEPTH edges after the first edge with reset_n high.
  - we is ignored; read_bank is held at 0; conflict stays 0.
- Reset asserted during INIT or RUN restarts INIT from pointer 0.
- RUN, writes:
  - For each port i with we[i]=1 and write_addr_i < DEPTH: entry[write_addr_i] <= i.
  - Equal addresses: the highest-numbered enabled port wins, so the entry takes the largest i.
  - conflict <= 1 on the next edge if any pair of enabled in-range ports share an address, else 0.
  - Writes with address >= DEPTH are dropped; they never count toward conflict.
- RUN, reads:
  - read_bank_j <= entry[read_addr_j] on every edge, giving 1-cycle latency with no enable.
  - read_addr_j >= DEPTH gives read_bank_j <= 0.
  - Read and write to the same address on the same edge returns the old entry (read-before-write), unless LVT_BYPASS_EN is defined.
- Multiple read ports may use identical addresses; each returns the same value independently.
- Width rules: the port index i is truncated to BANK_W bits (always fits by construction); comparisons against DEPTH use ADDR_W+1 bits.
- State is one entry array of DEPTH x BANK_W flops; no memory inference is required.

Optional Feature:
- Macro: LVT_BYPASS_EN.
- Defined: in RUN, if read_addr_j matches an enabled in-range write address on the same edge, read_bank_j takes the winning write port index (highest i) instead of the stored entry. Result: write-to-read visibility of 0 cycles, as seen at the registered output.
- Undefined: read-before-write as described in Behaviour; a new value is visible on the read output one edge after the write.
- Bypass is never active in INIT.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles, release. Expect ready=0 for exactly 16 edges (DEPTH=16), ready=1 after that. Then reading all 16 addresses returns 0.
- Single write: we=2'b10, write_addr_1=5; next cycle read_addr_0=5. Expect read_bank_0=1 one edge later, and conflict=0 throughout.
- Conflict: we=2'b11, write_addr_0=write_addr_1=7. Expect conflict=1 for exactly one cycle, and a later read of 7 returns 1.
- Read/write same edge: write port 0 to addr 3 (holding 1) while reading addr 3.
  - Without LVT_BYPASS_EN: read_bank=1, then 0 on the following read.
  - With LVT_BYPASS_EN: read_bank=0 immediately.
- Mid-init reset: assert reset_n=0 at init_ptr=9, release. Expect ready to stay low for a full 16 edges, and writes during INIT to have no effect (entry remains 0).
- Out-of-range: set DEPTH=12, ADDR_W=4; write addr 13 and read addr 14. Expect no entry change, read_bank=0, conflict=0.

Source files
------------

// File: rtl/lvt_nwmr_param_if.sv
// Bus bundle for lvt_nwmr_param: write-port enables/addresses, read addresses,
// and the registered live-bank / status outputs. The master drives the
// requests, and the slave (the LVT) drives the results.
interface lvt_nwmr_param_if #(
  parameter int NW     = 2,
  parameter int NR     = 4,
  parameter int ADDR_W = 4,
  parameter int BANK_W = 1
);
  logic [NW-1:0]        we;
  logic [NW*ADDR_W-1:0] write_addr;
  logic [NR*ADDR_W-1:0] read_addr;
  logic [NR*BANK_W-1:0] read_bank;
  logic                 ready;
  logic                 conflict;

  modport master (
    output we, write_addr, read_addr,
    input  read_bank, ready, conflict
  );

  modport slave (
    input  we, write_addr, read_addr,
    output read_bank, ready, conflict
  );
endinterface

// File: rtl/lvt_nwmr_param.sv
// Parametrised live value table for an NW-write / NR-read register file built
// from banked 1W/nR memories. Each entry records which write port last wrote
// that address; the registered read outputs steer the bank-select muxes.
// After reset, an INIT pass clears every entry before ready rises.
// When two or more enabled ports write the same in-range address, the
// highest-numbered port wins, and conflict pulses on the next cycle.
// Writes to addresses >= DEPTH are dropped. Reads of addresses >= DEPTH
// return 0.
// Optional macro LVT_BYPASS_EN: when it is defined, a read that hits a
// same-cycle write returns the winning write port instead of the stored entry.
module lvt_nwmr_param #(
  parameter int NW     = 2,
  parameter int NR     = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int BANK_W = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  lvt_nwmr_param_if.slave    bus
);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  // Address comparisons are one bit wider so that DEPTH == 2^ADDR_W still fits.
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   init_ptr_q, init_ptr_d;
  logic                ready_q, ready_d;
  logic                conflict_q, conflict_d;
  logic [NR*BANK_W-1:0] read_bank_q, read_bank_d;
  logic [BANK_W-1:0]   entry_q [DEPTH];

  logic [NW-1:0]       wr_valid;
  logic                wr_conflict;
  logic                hit [DEPTH];
  logic [BANK_W-1:0]   win_idx [DEPTH];

  // A write port only counts when it is enabled and its address is in range.
  generate
    for (genvar gi = 0; gi < NW; gi++) begin : g_wr_valid
      assign wr_valid[gi] = bus.we[gi] &&
                            ({1'b0, bus.write_addr[gi*ADDR_W +: ADDR_W]} < DEPTH_X);
    end
  endgenerate

  // Per-entry write resolution. An ascending scan lets the highest enabled port win.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_win
      always_comb begin
        hit[gi]     = 1'b0;
        win_idx[gi] = '0;
        for (int i = 0; i < NW; i++) begin
          if (wr_valid[i] && (bus.write_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(gi))) begin
            hit[gi]     = 1'b1;
            win_idx[gi] = BANK_W'(i);
          end
        end
      end
    end
  endgenerate

  // Detect any pair of valid write ports that target the same address.
  always_comb begin
    wr_conflict = 1'b0;
    for (int i = 0; i < NW; i++) begin
      for (int k = i + 1; k < NW; k++) begin
        if (wr_valid[i] && wr_valid[k] &&
            (bus.write_addr[i*ADDR_W +: ADDR_W] == bus.write_addr[k*ADDR_W +: ADDR_W])) begin
          wr_conflict = 1'b1;
        end
      end
    end
  end

  // State register: reset restarts the INIT sweep from entry 0.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= INIT;
      init_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
    end
  end

  // Next state: sweep every entry once, then move to RUN after the last entry.
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    case (state_q)
      INIT: begin
        if (init_ptr_q == LAST_PTR) begin
          state_d = RUN;
        end else begin
          init_ptr_d = init_ptr_q + 1'b1;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // Output next-values: reads and conflict are live only in RUN; ready follows the state.
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [BANK_W-1:0] val;
    ready_d     = (state_d == RUN);
    conflict_d  = (state_q == RUN) && wr_conflict;
    read_bank_d = '0;
    for (int j = 0; j < NR; j++) begin
      ra  = bus.read_addr[j*ADDR_W +: ADDR_W];
      val = '0;
      for (int e = 0; e < DEPTH; e++) begin
        if (ra == ADDR_W'(e)) begin
`ifdef LVT_BYPASS_EN
          val = hit[e] ? win_idx[e] : entry_q[e];
`else
          val = entry_q[e];
`endif
        end
      end
      if (state_q == RUN) begin
        read_bank_d[j*BANK_W +: BANK_W] = val;
      end
    end
  end

  // Registered outputs: cleared by reset, then loaded every edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ready_q     <= 1'b0;
      conflict_q  <= 1'b0;
      read_bank_q <= '0;
    end else begin
      ready_q     <= ready_d;
      conflict_q  <= conflict_d;
      read_bank_q <= read_bank_d;
    end
  end

  // Table entries: INIT clears one entry per cycle, and RUN stores the winning port.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clock) begin
        if (reset_n) begin
          if ((state_q == INIT) && (init_ptr_q == ADDR_W'(gi))) begin
            entry_q[gi] <= '0;
          end else if ((state_q == RUN) && hit[gi]) begin
            entry_q[gi] <= win_idx[gi];
          end
        end
      end
    end
  endgenerate

  assign bus.ready     = ready_q;
  assign bus.conflict  = conflict_q;
  assign bus.read_bank = read_bank_q;

endmodule

// File: tb/tb_lvt_nwmr_param.sv
// Bench for lvt_nwmr_param. Two instances (DEPTH 16 and DEPTH 12) share the
// same stimulus. Every edge is compared against a per-instance table model.
// Build with +define+LVT_BYPASS_EN to exercise the bypass variant.
module tb_lvt_nwmr_param;
  localparam int NW = 2, NR = 4, ADDR_W = 4, BANK_W = 1;
  localparam int DA = 16, DB = 12;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [NW-1:0]        we = '0;
  logic [NW*ADDR_W-1:0] waddr = '0;
  logic [NR*ADDR_W-1:0] raddr = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: one table per instance, plus edges spent in INIT.
  int mem [2][16];
  int cnt [2];
  int depth [2];

  lvt_nwmr_param_if #(.NW(NW), .NR(NR), .ADDR_W(ADDR_W), .BANK_W(BANK_W)) bus_a ();
  lvt_nwmr_param_if #(.NW(NW), .NR(NR), .ADDR_W(ADDR_W), .BANK_W(BANK_W)) bus_b ();

  assign bus_a.we = we;
  assign bus_a.write_addr = waddr;
  assign bus_a.read_addr = raddr;
  assign bus_b.we = we;
  assign bus_b.write_addr = waddr;
  assign bus_b.read_addr = raddr;

  lvt_nwmr_param #(.NW(NW), .NR(NR), .DEPTH(DA), .ADDR_W(ADDR_W), .BANK_W(BANK_W)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(bus_a));
  lvt_nwmr_param #(.NW(NW), .NR(NR), .DEPTH(DB), .ADDR_W(ADDR_W), .BANK_W(BANK_W)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(bus_b));

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge: predict each instance from the spec rules, then compare after the edge.
  task automatic step();
    int exp_rb [2][NR];
    int exp_rdy [2];
    int exp_cf [2];
    int a, wa, wb, v;
    for (int k = 0; k < 2; k++) begin
      exp_cf[k] = 0;
      for (int j = 0; j < NR; j++) exp_rb[k][j] = 0;
      if (!reset_n) begin
        cnt[k] = 0;
        exp_rdy[k] = 0;
      end else if (cnt[k] < depth[k]) begin
        cnt[k]++;
        exp_rdy[k] = (cnt[k] == depth[k]) ? 1 : 0;
        if (exp_rdy[k] == 1) begin
          for (int e = 0; e < 16; e++) mem[k][e] = 0;
        end
      end else begin
        exp_rdy[k] = 1;
        for (int j = 0; j < NR; j++) begin
          a = int'(raddr[j*ADDR_W +: ADDR_W]);
          v = 0;
          if (a < depth[k]) begin
            v = mem[k][a];
`ifdef LVT_BYPASS_EN
            for (int i = 0; i < NW; i++)
              if (we[i] && int'(waddr[i*ADDR_W +: ADDR_W]) == a) v = i;
`endif
          end
          exp_rb[k][j] = v;
        end
        for (int i = 0; i < NW; i++) begin
          for (int i2 = i + 1; i2 < NW; i2++) begin
            wa = int'(waddr[i*ADDR_W +: ADDR_W]);
            wb = int'(waddr[i2*ADDR_W +: ADDR_W]);
            if (we[i] && we[i2] && wa == wb && wa < depth[k]) exp_cf[k] = 1;
          end
        end
        for (int i = 0; i < NW; i++) begin
          wa = int'(waddr[i*ADDR_W +: ADDR_W]);
          if (we[i] && wa < depth[k]) mem[k][wa] = i;
        end
      end
    end
    @(posedge clock);
    #1;
    check_eq("a.ready", 32'(bus_a.ready), 32'(exp_rdy[0]));
    check_eq("a.conflict", 32'(bus_a.conflict), 32'(exp_cf[0]));
    check_eq("b.ready", 32'(bus_b.ready), 32'(exp_rdy[1]));
    check_eq("b.conflict", 32'(bus_b.conflict), 32'(exp_cf[1]));
    for (int j = 0; j < NR; j++) begin
      check_eq($sformatf("a.read_bank%0d", j), 32'(bus_a.read_bank[j*BANK_W +: BANK_W]),
               32'(exp_rb[0][j]));
      check_eq($sformatf("b.read_bank%0d", j), 32'(bus_b.read_bank[j*BANK_W +: BANK_W]),
               32'(exp_rb[1][j]));
    end
    $display("t=%0t rst_n=%b we=%b wa=%h ra=%h | a rdy=%b cf=%b rb=%b | b rdy=%b cf=%b rb=%b",
             $time, reset_n, we, waddr, raddr, bus_a.ready, bus_a.conflict, bus_a.read_bank,
             bus_b.ready, bus_b.conflict, bus_b.read_bank);
  endtask

  task automatic drive(input logic rn, input logic [1:0] w, input int a0, input int a1,
                       input int r0, input int r1, input int r2, input int r3);
    reset_n = rn;
    we      = w;
    waddr   = {4'(a1), 4'(a0)};
    raddr   = {4'(r3), 4'(r2), 4'(r1), 4'(r0)};
    step();
  endtask

  task automatic read_all();
    for (int b = 0; b < 4; b++) drive(1'b1, 2'b00, 0, 0, 4*b, 4*b+1, 4*b+2, 4*b+3);
  endtask

  task automatic init_with_noise(input int n);
    for (int c = 0; c < n; c++)
      drive(1'b1, 2'b11, $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 15));
  endtask

  initial begin
    int a0, a1;
    depth[0] = DA;
    depth[1] = DB;
    cnt[0] = 0;
    cnt[1] = 0;
    for (int k = 0; k < 2; k++)
      for (int e = 0; e < 16; e++) mem[k][e] = 0;

    // Reset for three edges, then a full INIT sweep with writes that must be ignored.
    for (int c = 0; c < 3; c++) drive(1'b0, 2'b11, 1, 2, 1, 2, 3, 4);
    init_with_noise(DA);
    read_all();

    // Single write from port 1, then read it back on all ports.
    drive(1'b1, 2'b10, 0, 5, 0, 0, 0, 0);
    drive(1'b1, 2'b00, 0, 0, 5, 5, 5, 5);
    // Same-address write conflict; the higher port wins.
    drive(1'b1, 2'b11, 7, 7, 0, 0, 0, 0);
    drive(1'b1, 2'b00, 0, 0, 7, 7, 7, 7);
    drive(1'b1, 2'b00, 0, 0, 7, 7, 7, 7);
    // Read and write the same address on the same edge.
    drive(1'b1, 2'b10, 0, 3, 0, 0, 0, 0);
    drive(1'b1, 2'b01, 3, 0, 3, 3, 3, 3);
    drive(1'b1, 2'b00, 0, 0, 3, 3, 3, 3);
    // Out-of-range for the DEPTH 12 instance; an in-range conflict for DEPTH 16.
    drive(1'b1, 2'b11, 13, 13, 14, 14, 13, 14);
    drive(1'b1, 2'b10, 0, 13, 14, 13, 12, 11);
    drive(1'b1, 2'b00, 0, 0, 13, 14, 12, 11);

    // Reset partway through INIT, then sweep again with write noise and read all entries.
    drive(1'b0, 2'b00, 0, 0, 0, 0, 0, 0);
    init_with_noise(9);
    drive(1'b0, 2'b11, 9, 9, 9, 9, 9, 9);
    init_with_noise(DA);
    read_all();

    // Random traffic with biased address collisions and rare resets.
    for (int n = 0; n < 400; n++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      we = 2'($urandom_range(0, 3));
      a0 = $urandom_range(0, 15);
      a1 = ($urandom_range(0, 3) == 0) ? a0 : $urandom_range(0, 15);
      waddr = {4'(a1), 4'(a0)};
      for (int j = 0; j < NR; j++) begin
        case ($urandom_range(0, 3))
          0:       raddr[j*ADDR_W +: ADDR_W] = 4'(a0);
          1:       raddr[j*ADDR_W +: ADDR_W] = 4'(a1);
          default: raddr[j*ADDR_W +: ADDR_W] = 4'($urandom_range(0, 15));
        endcase
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
